// File: rtl/studio_keypad.sv
// Studio keypad scanner: PS/2 digits to two 10-key pads with EF3/EF4 flags.
// Define STUDIO_KEYPAD2_EN to build keypad 2; otherwise it reads idle.
module studio_keypad #(
  parameter logic [15:0] MIN_HOLD = 16'd2000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [10:0] ps2_key,
  input  logic        io_out,
  input  logic [2:0]  io_n,
  input  logic [7:0]  io_dout,
  output logic        ef3_n,
  output logic        ef4_n,
  output logic [3:0]  key_sel,
  output logic [9:0]  kp1_keys,
  output logic [9:0]  kp2_keys
);

  // Returns {hit, digit}.
  function automatic logic [4:0] map1(input logic [7:0] c);
    unique case (c)
      8'h45:   map1 = 5'h10;
      8'h16:   map1 = 5'h11;
      8'h1E:   map1 = 5'h12;
      8'h26:   map1 = 5'h13;
      8'h25:   map1 = 5'h14;
      8'h2E:   map1 = 5'h15;
      8'h36:   map1 = 5'h16;
      8'h3D:   map1 = 5'h17;
      8'h3E:   map1 = 5'h18;
      8'h46:   map1 = 5'h19;
      default: map1 = 5'h00;
    endcase
  endfunction

  logic             tog_q, tog_d;
  logic             prime_q, prime_d;
  logic             evt, is_make, sel_ok;
  logic [4:0]       m1;
  logic             hit1;
  logic [9:0]       held1_q, held1_d;
  logic [9:0]       kp1_q, kp1_d;
  logic [9:0][15:0] cnt1_q, cnt1_d;
  logic [3:0]       key_sel_q, key_sel_d;
  logic             ef3_q, ef3_d;
  logic [15:0]      kp1_pad;

  assign evt     = !prime_q && (ps2_key[10] != tog_q);
  assign is_make = ps2_key[9];
  assign sel_ok  = key_sel_q <= 4'd9;

  always_comb begin
    prime_d   = 1'b0;
    tog_d     = ps2_key[10];
    key_sel_d = key_sel_q;
    if (io_out && io_n == 3'b010)
      key_sel_d = io_dout[3:0];
    m1      = map1(ps2_key[7:0]);
    hit1    = evt && !ps2_key[8] && m1[4];
    held1_d = held1_q;
    for (int k = 0; k < 10; k++) begin
      cnt1_d[k] = (cnt1_q[k] != 16'd0) ? cnt1_q[k] - 16'd1 : 16'd0;
      kp1_d[k]  = held1_q[k] | (cnt1_q[k] != 16'd0);
    end
    // A make reload takes priority over the per-cycle decrement.
    if (hit1) begin
      if (is_make) begin
        held1_d[m1[3:0]] = 1'b1;
        cnt1_d[m1[3:0]]  = MIN_HOLD;
      end else begin
        held1_d[m1[3:0]] = 1'b0;
      end
    end
    kp1_pad = {6'd0, kp1_q};
    ef3_d   = !(sel_ok && kp1_pad[key_sel_q]);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tog_q     <= 1'b0;
      prime_q   <= 1'b1;
      held1_q   <= '0;
      cnt1_q    <= '0;
      kp1_q     <= '0;
      key_sel_q <= 4'hF;
      ef3_q     <= 1'b1;
    end else begin
      tog_q     <= tog_d;
      prime_q   <= prime_d;
      held1_q   <= held1_d;
      cnt1_q    <= cnt1_d;
      kp1_q     <= kp1_d;
      key_sel_q <= key_sel_d;
      ef3_q     <= ef3_d;
    end
  end

  assign ef3_n    = ef3_q;
  assign key_sel  = key_sel_q;
  assign kp1_keys = kp1_q;

`ifdef STUDIO_KEYPAD2_EN
  function automatic logic [4:0] map2(input logic [7:0] c);
    unique case (c)
      8'h70:   map2 = 5'h10;
      8'h69:   map2 = 5'h11;
      8'h72:   map2 = 5'h12;
      8'h7A:   map2 = 5'h13;
      8'h6B:   map2 = 5'h14;
      8'h73:   map2 = 5'h15;
      8'h74:   map2 = 5'h16;
      8'h6C:   map2 = 5'h17;
      8'h75:   map2 = 5'h18;
      8'h7D:   map2 = 5'h19;
      default: map2 = 5'h00;
    endcase
  endfunction

  logic [4:0]       m2;
  logic             hit2;
  logic [9:0]       held2_q, held2_d;
  logic [9:0]       kp2_q, kp2_d;
  logic [9:0][15:0] cnt2_q, cnt2_d;
  logic             ef4_q, ef4_d;
  logic [15:0]      kp2_pad;

  always_comb begin
    m2      = map2(ps2_key[7:0]);
    hit2    = evt && !ps2_key[8] && m2[4];
    held2_d = held2_q;
    for (int k = 0; k < 10; k++) begin
      cnt2_d[k] = (cnt2_q[k] != 16'd0) ? cnt2_q[k] - 16'd1 : 16'd0;
      kp2_d[k]  = held2_q[k] | (cnt2_q[k] != 16'd0);
    end
    if (hit2) begin
      if (is_make) begin
        held2_d[m2[3:0]] = 1'b1;
        cnt2_d[m2[3:0]]  = MIN_HOLD;
      end else begin
        held2_d[m2[3:0]] = 1'b0;
      end
    end
    kp2_pad = {6'd0, kp2_q};
    ef4_d   = !(sel_ok && kp2_pad[key_sel_q]);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      held2_q <= '0;
      cnt2_q  <= '0;
      kp2_q   <= '0;
      ef4_q   <= 1'b1;
    end else begin
      held2_q <= held2_d;
      cnt2_q  <= cnt2_d;
      kp2_q   <= kp2_d;
      ef4_q   <= ef4_d;
    end
  end

  assign ef4_n    = ef4_q;
  assign kp2_keys = kp2_q;
`else
  assign ef4_n    = 1'b1;
  assign kp2_keys = '0;
`endif

endmodule

// File: tb/tb_studio_keypad.sv
// Directed bench for studio_keypad with a short hold stretch.
// Keypad-2 expectations follow STUDIO_KEYPAD2_EN.
module tb_studio_keypad;

`ifdef STUDIO_KEYPAD2_EN
  localparam bit KP2 = 1'b1;
`else
  localparam bit KP2 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetq;
  logic [10:0] ps2_key;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  io_dout;
  logic        ef3_n, ef4_n;
  logic [3:0]  key_sel;
  logic [9:0]  kp1_keys, kp2_keys;
  logic        tog;
  int          checks = 0;
  int          errors = 0;

  studio_keypad #(.MIN_HOLD(16'd10)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .ps2_key  (ps2_key),
    .io_out   (io_out),
    .io_n     (io_n),
    .io_dout  (io_dout),
    .ef3_n    (ef3_n),
    .ef4_n    (ef4_n),
    .key_sel  (key_sel),
    .kp1_keys (kp1_keys),
    .kp2_keys (kp2_keys)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ps2_set(input logic mk, input logic ext,
                         input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, mk, ext, code};
  endtask

  task automatic send(input logic mk, input logic ext,
                      input logic [7:0] code);
    ps2_set(mk, ext, code);
    step();
  endtask

  task automatic out(input logic [2:0] n, input logic [7:0] d);
    io_out  = 1'b1;
    io_n    = n;
    io_dout = d;
    step();
    io_out  = 1'b0;
  endtask

  initial begin
    resetq  = 1'b0;
    tog     = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h45};
    io_out  = 1'b0;
    io_n    = 3'd0;
    io_dout = 8'd0;
    idle(2);
    check("rst_ef3", ef3_n, 1);
    check("rst_ef4", ef4_n, 1);
    check("rst_sel", key_sel, 4'hF);
    check("rst_kp1", kp1_keys, 0);
    check("rst_kp2", kp2_keys, 0);

    // Toggle already high at release: priming must swallow it.
    resetq = 1'b1;
    idle(4);
    check("prime_kp1", kp1_keys, 0);
    check("prime_ef3", ef3_n, 1);

    out(3'b010, 8'h05);
    check("sel5", key_sel, 4'h5);
    send(1'b1, 1'b0, 8'h2E);
    check("kp1_lat0", kp1_keys, 10'h000);
    step();
    check("kp1_5", kp1_keys, 10'h020);
    check("ef3_lat", ef3_n, 1);
    step();
    check("ef3_5", ef3_n, 0);
    check("ef4_5", ef4_n, 1);
    send(1'b0, 1'b0, 8'h2E);
    idle(15);
    check("rel_kp1", kp1_keys, 0);
    check("rel_ef3", ef3_n, 1);

    // Stretch: make at edge M, break at M+2, hold of 10.
    out(3'b010, 8'h01);
    send(1'b1, 1'b0, 8'h16);
    for (int i = 1; i <= 13; i++) begin
      if (i == 2) ps2_set(1'b0, 1'b0, 8'h16);
      step();
      check($sformatf("hold_kp1_%0d", i), kp1_keys[1],
            (i >= 1 && i <= 10));
      check($sformatf("hold_ef3_%0d", i), ef3_n,
            !(i >= 2 && i <= 11));
    end

    send(1'b1, 1'b1, 8'h45);
    send(1'b1, 1'b0, 8'h1C);
    idle(3);
    check("ign_kp1", kp1_keys, 0);
    check("ign_kp2", kp2_keys, 0);

    send(1'b1, 1'b0, 8'h45);
    send(1'b1, 1'b0, 8'h70);
    out(3'b010, 8'h0C);
    idle(2);
    check("selC", key_sel, 4'hC);
    check("selC_ef3", ef3_n, 1);
    check("selC_ef4", ef4_n, 1);
    check("multi_kp1", kp1_keys, 10'h001);
    check("multi_kp2", kp2_keys, KP2 ? 10'h001 : 10'h000);
    out(3'b011, 8'h00);
    check("n3_sel", key_sel, 4'hC);
    out(3'b010, 8'h00);
    idle(2);
    check("sel0_ef3", ef3_n, 0);
    check("sel0_ef4", ef4_n, KP2 ? 1'b0 : 1'b1);
    send(1'b0, 1'b0, 8'h45);
    send(1'b0, 1'b0, 8'h70);
    idle(15);
    check("multi_rel", kp1_keys, 0);

    out(3'b010, 8'h01);
    send(1'b1, 1'b0, 8'h69);
    idle(3);
    check("kp2_keys", kp2_keys, KP2 ? 10'h002 : 10'h000);
    check("kp2_ef4", ef4_n, KP2 ? 1'b0 : 1'b1);
    check("kp2_ef3", ef3_n, 1);
    send(1'b0, 1'b0, 8'h69);
    idle(15);

    send(1'b1, 1'b0, 8'h3E);
    out(3'b010, 8'h08);
    idle(3);
    check("k8_kp1", kp1_keys, 10'h100);
    check("k8_ef3", ef3_n, 0);
    #2;
    resetq = 1'b0;
    #1;
    check("arst_ef3", ef3_n, 1);
    check("arst_ef4", ef4_n, 1);
    check("arst_sel", key_sel, 4'hF);
    check("arst_kp1", kp1_keys, 0);
    check("arst_kp2", kp2_keys, 0);
    #1;
    resetq = 1'b1;
    idle(4);
    check("post_kp1", kp1_keys, 0);
    check("post_sel", key_sel, 4'hF);
    check("post_ef3", ef3_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
